// File: rtl/gray_conv_arbiter.sv
// Two requesters share one binary-to-Gray converter and a one-entry result slot.
// Ties between the requesters are settled round-robin.
module gray_conv_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] bin0,
  input  logic       req1,
  input  logic [3:0] bin1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       out_valid,
  output logic [3:0] out_gray,
  output logic       out_src,
  input  logic       out_ready,
  output logic [7:0] xfer_cnt
);

  logic       last_gnt;
  logic       slot_free;
  logic       any_gnt;
  logic       drain;
  logic [3:0] sel_bin;
  logic [3:0] conv_gray;

  // A drain and a new grant can happen on the same edge, so the slot only needs to be
  // free after this edge's drain.
  always_comb begin
    slot_free = !out_valid || out_ready;
    drain     = out_valid && out_ready;
    gnt0      = !rst && slot_free && req0 && (!req1 || last_gnt);
    gnt1      = !rst && slot_free && req1 && (!req0 || !last_gnt);
    any_gnt   = gnt0 || gnt1;
    sel_bin   = gnt1 ? bin1 : bin0;
    conv_gray = {sel_bin[3], sel_bin[3:1] ^ sel_bin[2:0]};
  end

  // last_gnt resets to 1 so that the first tie goes to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (any_gnt) begin
      last_gnt <= gnt1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_gray  <= 4'b0000;
      out_src   <= 1'b0;
    end else if (any_gnt) begin
      out_valid <= 1'b1;
      out_gray  <= conv_gray;
      out_src   <= gnt1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= 8'd0;
    end else if (drain) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter: inputs change on the falling edge, and
// outputs are sampled on the falling edge or just after it.
module tb_gray_conv_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [3:0] bin0;
  logic       req1;
  logic [3:0] bin1;
  logic       gnt0;
  logic       gnt1;
  logic       out_valid;
  logic [3:0] out_gray;
  logic       out_src;
  logic       out_ready;
  logic [7:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_conv_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .bin0      (bin0),
    .req1      (req1),
    .bin1      (bin1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_src   (out_src),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; bin0 = 4'b1010; bin1 = 4'b0101; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_gnt: got %b expected 00", {gnt0, gnt1});
    end
    total++;
    if ({out_valid, out_src, out_gray, xfer_cnt} !== 14'd0) begin
      bad++; $display("[TB] FAIL reset_state: got v=%b s=%b g=%b c=%0d expected all zero",
                      out_valid, out_src, out_gray, xfer_cnt);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; bin0 = 4'b1011; out_ready = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++; $display("[TB] FAIL single_gnt: got %b expected 10", {gnt0, gnt1});
    end
    @(negedge clk);
    req0 = 1'b0;
    total++;
    if ({out_valid, out_src, out_gray} !== 6'b1_0_1110) begin
      bad++; $display("[TB] FAIL single_result: got v=%b s=%b g=%b expected v=1 s=0 g=1110",
                      out_valid, out_src, out_gray);
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_src, out_gray, xfer_cnt} !== {6'b0_0_1110, 8'd1}) begin
      bad++; $display("[TB] FAIL single_drain: got v=%b s=%b g=%b c=%0d expected v=0 s=0 g=1110 c=1",
                      out_valid, out_src, out_gray, xfer_cnt);
    end
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; bin0 = 4'b0101; bin1 = 4'b1111; out_ready = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++; $display("[TB] FAIL tie_first_gnt: got %b expected 10", {gnt0, gnt1});
    end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    total++;
    if ({out_valid, out_src, out_gray, gnt1} !== 7'b1_0_0111_1) begin
      bad++; $display("[TB] FAIL tie_first_result: got v=%b s=%b g=%b gnt1=%b expected v=1 s=0 g=0111 gnt1=1",
                      out_valid, out_src, out_gray, gnt1);
    end
    @(negedge clk);
    req1 = 1'b0;
    total++;
    if ({out_valid, out_src, out_gray, xfer_cnt} !== {6'b1_1_1000, 8'd1}) begin
      bad++; $display("[TB] FAIL tie_second_result: got v=%b s=%b g=%b c=%0d expected v=1 s=1 g=1000 c=1",
                      out_valid, out_src, out_gray, xfer_cnt);
    end
    @(negedge clk);
    total++;
    if ({out_valid, xfer_cnt} !== {1'b0, 8'd2}) begin
      bad++; $display("[TB] FAIL tie_count: got v=%b c=%0d expected v=0 c=2", out_valid, xfer_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req0 = 1'b1; bin0 = 4'b0011; out_ready = 1'b0;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b1; bin1 = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({gnt1, out_valid, out_src, out_gray, xfer_cnt} !== {7'b0_1_0_0010, 8'd0}) begin
        bad++; $display("[TB] FAIL stall_%0d: got gnt1=%b v=%b s=%b g=%b c=%0d expected gnt1=0 v=1 s=0 g=0010 c=0",
                        i, gnt1, out_valid, out_src, out_gray, xfer_cnt);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b01) begin
      bad++; $display("[TB] FAIL release_gnt: got %b expected 01", {gnt0, gnt1});
    end
    @(negedge clk);
    req1 = 1'b0;
    total++;
    if ({out_valid, out_src, out_gray, xfer_cnt} !== {6'b1_1_0101, 8'd1}) begin
      bad++; $display("[TB] FAIL release_result: got v=%b s=%b g=%b c=%0d expected v=1 s=1 g=0101 c=1",
                      out_valid, out_src, out_gray, xfer_cnt);
    end
  endtask

  task automatic test_exhaustive();
    do_reset();
    out_ready = 1'b1; req1 = 1'b1; bin1 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++;
      if (gnt1 !== 1'b1) begin
        bad++; $display("[TB] FAIL exh_gnt_%0d: got %b expected 1", i, gnt1);
      end
      @(negedge clk);
      total++;
      if ({out_valid, out_src, out_gray} !== {2'b11, gray_tab[i]}) begin
        bad++; $display("[TB] FAIL exh_gray_%0d: got v=%b s=%b g=%b expected v=1 s=1 g=%b",
                        i, out_valid, out_src, out_gray, gray_tab[i]);
      end
      bin1 = 4'(i + 1);
    end
    req1 = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, xfer_cnt} !== {1'b0, 8'd16}) begin
      bad++; $display("[TB] FAIL exh_count: got v=%b c=%0d expected v=0 c=16", out_valid, xfer_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b1; req1 = 1'b1; bin1 = 4'b0001;
    repeat (8) @(negedge clk);
    req1 = 1'b0; out_ready = 1'b0;
    total++;
    if ({out_valid, xfer_cnt} !== {1'b1, 8'd7}) begin
      bad++; $display("[TB] FAIL pre_reset: got v=%b c=%0d expected v=1 c=7", out_valid, xfer_cnt);
    end
    #2;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    #1;
    total++;
    if ({out_valid, gnt0, gnt1, xfer_cnt} !== 11'd0) begin
      bad++; $display("[TB] FAIL async_reset: got v=%b gnt=%b%b c=%0d expected v=0 gnt=00 c=0",
                      out_valid, gnt0, gnt1, xfer_cnt);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; bin0 = 4'b1100; bin1 = 4'b0011;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++; $display("[TB] FAIL reset_tie_gnt: got %b expected 10", {gnt0, gnt1});
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    total++;
    if ({out_valid, out_src, out_gray, xfer_cnt} !== {6'b1_0_1010, 8'd0}) begin
      bad++; $display("[TB] FAIL reset_tie_result: got v=%b s=%b g=%b c=%0d expected v=1 s=0 g=1010 c=0",
                      out_valid, out_src, out_gray, xfer_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; req0 = 1'b1; bin0 = 4'b0110;
    repeat (256) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, xfer_cnt} !== {1'b1, 8'd255}) begin
      bad++; $display("[TB] FAIL wrap_255: got v=%b c=%0d expected v=1 c=255", out_valid, xfer_cnt);
    end
    req0 = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, xfer_cnt} !== {1'b0, 8'd0}) begin
      bad++; $display("[TB] FAIL wrap_256: got v=%b c=%0d expected v=0 c=0", out_valid, xfer_cnt);
    end
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, xfer_cnt} !== {1'b0, 8'd1}) begin
      bad++; $display("[TB] FAIL wrap_257: got v=%b c=%0d expected v=0 c=1", out_valid, xfer_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_exhaustive();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
